// File: rtl/triangle_generator_pkg.sv
// rtl/triangle_generator_pkg.sv - shared types and width defaults for the triangle ramp generator
package triangle_pkg;

  // Ramp phases: climbing, dwelling at the peak, falling, dwelling at the trough.
  typedef enum logic [1:0] {
    S_UP       = 2'd0,
    S_HOLD_TOP = 2'd1,
    S_DOWN     = 2'd2,
    S_HOLD_BOT = 2'd3
  } tri_state_t;

  // Default widths: ramp value / bounds / step, and dwell count.
  localparam int DEF_N = 8;
  localparam int DEF_D = 4;

  // Direction flag carried by each phase: rising side includes the peak dwell.
  function automatic logic state_is_rising(input tri_state_t s);
    return (s == S_UP) || (s == S_HOLD_TOP);
  endfunction

endpackage

// File: rtl/triangle_generator_if.sv
// rtl/triangle_generator_if.sv - control and ramp-output bundle for the triangle generator
interface triangle_generator_if #(
  parameter int N = triangle_pkg::DEF_N,
  parameter int D = triangle_pkg::DEF_D
);

  logic         ena;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic [N-1:0] step;
  logic [D-1:0] dwell;
  logic [N-1:0] out;
  logic         dir;
  logic         at_peak;
  logic         at_trough;

  // Side that supplies the tick, bounds and step, and watches the ramp.
  modport master (
    output ena, lo, hi, step, dwell,
    input  out, dir, at_peak, at_trough
  );

  // Side that produces the ramp.
  modport slave (
    input  ena, lo, hi, step, dwell,
    output out, dir, at_peak, at_trough
  );

endinterface

// File: rtl/triangle_generator_comparator_eq.sv
// rtl/triangle_generator_comparator_eq.sv - N-bit equality comparator used for dwell expiry
module comparator_eq #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  // Pure combinational match.
  always_comb begin
    eq = (a == b);
  end

endmodule

// File: rtl/triangle_generator.sv
// rtl/triangle_generator.sv - bounded up/down ramp with dwell at each extreme and peak/trough flags
module triangle_generator
  import triangle_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int D = DEF_D
) (
  input logic                 clk,
  input logic                 rst,
  triangle_generator_if.slave bus
);

  tri_state_t   state_q, state_d;
  logic [N-1:0] out_q, out_d;
  logic [D-1:0] cnt_q, cnt_d;
  logic         dir_q, dir_d;
  logic         peak_q, peak_d;
  logic         trough_q, trough_d;

  logic [N-1:0] step_eff;
  logic [N:0]   sum_up;
  logic [N:0]   down_floor;
  logic [N-1:0] diff_down;
  logic [D-1:0] cnt_inc;
  logic         cnt_match;
  logic         hold_done;
  logic         degenerate;

  // Dwell expiry: the incremented count reaches the programmed dwell.
  comparator_eq #(.N(D)) u_dwell_eq (
    .a  (cnt_inc),
    .b  (bus.dwell),
    .eq (cnt_match)
  );

  // Arithmetic for both ramp directions; sums are one bit wider so nothing wraps.
  always_comb begin
    step_eff   = (bus.step == '0) ? N'(1) : bus.step;
    sum_up     = {1'b0, out_q} + {1'b0, step_eff};
    down_floor = {1'b0, bus.lo} + {1'b0, step_eff};
    diff_down  = out_q - step_eff;
    cnt_inc    = cnt_q + D'(1);
    // A live dwell lowered below the elapsed count ends the hold on this tick.
    hold_done  = cnt_match || (cnt_q >= bus.dwell);
    degenerate = (bus.lo >= bus.hi);
  end

  // Next-state, next-value and flag decode; nothing moves without a tick.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    peak_d   = 1'b0;
    trough_d = 1'b0;

    if (bus.ena) begin
      if (degenerate) begin
        // Empty range: park at lo on the rising side with no flags.
        out_d   = bus.lo;
        state_d = S_UP;
        dir_d   = 1'b1;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          S_UP: begin
            if (sum_up >= {1'b0, bus.hi}) begin
              out_d  = bus.hi;
              peak_d = 1'b1;
              cnt_d  = '0;
              if (bus.dwell != '0) begin
                state_d = S_HOLD_TOP;
              end else begin
                state_d = S_DOWN;
              end
            end else if (sum_up < {1'b0, bus.lo}) begin
              // lo was raised above the ramp: pull up to the new floor.
              out_d = bus.lo;
            end else begin
              out_d = sum_up[N-1:0];
            end
          end

          S_HOLD_TOP: begin
            if (hold_done) begin
              cnt_d   = '0;
              state_d = S_DOWN;
              out_d   = bus.hi;
            end else begin
              cnt_d = cnt_inc;
            end
          end

          S_DOWN: begin
            if ({1'b0, out_q} <= down_floor) begin
              out_d    = bus.lo;
              trough_d = 1'b1;
              cnt_d    = '0;
              if (bus.dwell != '0) begin
                state_d = S_HOLD_BOT;
              end else begin
                state_d = S_UP;
              end
            end else if (diff_down > bus.hi) begin
              // hi was lowered below the ramp: pull down to the new ceiling.
              out_d = bus.hi;
            end else begin
              out_d = diff_down;
            end
          end

          S_HOLD_BOT: begin
            if (hold_done) begin
              cnt_d   = '0;
              state_d = S_UP;
              out_d   = bus.lo;
            end else begin
              cnt_d = cnt_inc;
            end
          end

          default: begin
            state_d = S_UP;
            cnt_d   = '0;
          end
        endcase
        dir_d = state_is_rising(state_d);
      end
    end
  end

  // State, ramp value, dwell count and flag registers; reset wins over the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_UP;
      out_q    <= bus.lo;
      cnt_q    <= '0;
      dir_q    <= 1'b1;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.dir       = dir_q;
  assign bus.at_peak   = peak_q;
  assign bus.at_trough = trough_q;

endmodule

// File: tb/tb_triangle_generator.sv
// tb/tb_triangle_generator.sv - self-checking bench for triangle_generator
module tb_triangle_generator;

  localparam int N = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  triangle_generator_if #(.N(N), .D(D)) bus ();

  triangle_generator #(.N(N), .D(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit r;
    bit e;
    int lo;
    int hi;
    int st;
    int dw;
    int out;
    bit dir;
    bit pk;
    bit tr;
  } vec_t;

  vec_t vt[$];

  // reference model: ramp value, side, and dwell progress in plain integers
  int m_val;
  bit m_rising;
  bit m_holding;
  int m_held;
  bit m_peak;
  bit m_trough;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit e, input int l, input int h, input int s, input int d);
    rst       = r;
    bus.ena   = e;
    bus.lo    = N'(l);
    bus.hi    = N'(h);
    bus.step  = N'(s);
    bus.dwell = D'(d);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input bit r, input bit e, input int lo, input int hi, input int st,
                              input int dw, input int o, input bit di, input bit pk, input bit tr);
    vec_t v;
    v.r = r; v.e = e; v.lo = lo; v.hi = hi; v.st = st; v.dw = dw;
    v.out = o; v.dir = di; v.pk = pk; v.tr = tr;
    vt.push_back(v);
  endfunction

  function automatic void model_step(input bit r, input bit e, input int l, input int h,
                                     input int s, input int d);
    int sv;
    sv = (s == 0) ? 1 : s;
    m_peak   = 1'b0;
    m_trough = 1'b0;
    if (r) begin
      m_val = l; m_rising = 1'b1; m_holding = 1'b0; m_held = 0;
    end else if (e) begin
      if (l >= h) begin
        m_val = l; m_rising = 1'b1; m_holding = 1'b0; m_held = 0;
      end else if (m_holding) begin
        if (m_held + 1 >= d) begin
          m_holding = 1'b0;
          m_held    = 0;
          m_val     = m_rising ? h : l;
          m_rising  = !m_rising;
        end else begin
          m_held++;
        end
      end else if (m_rising) begin
        if (m_val + sv >= h) begin
          m_val  = h;
          m_peak = 1'b1;
          m_held = 0;
          if (d > 0) m_holding = 1'b1;
          else       m_rising  = 1'b0;
        end else begin
          m_val = (m_val + sv < l) ? l : m_val + sv;
        end
      end else begin
        if (m_val - sv <= l) begin
          m_val    = l;
          m_trough = 1'b1;
          m_held   = 0;
          if (d > 0) m_holding = 1'b1;
          else       m_rising  = 1'b1;
        end else begin
          m_val = (m_val - sv > h) ? h : m_val - sv;
        end
      end
    end
  endfunction

  int l, h, s, d;
  bit r, e;

  initial begin
    drive(1, 0, 0, 0, 0, 0);

    // reset state with ena ignored, then the dwell-free 0..20 ramp
    add(1, 1, 10, 100, 5, 0, 10, 1, 0, 0);
    add(1, 0, 0, 20, 5, 0, 0, 1, 0, 0);
    add(0, 1, 0, 20, 5, 0, 5, 1, 0, 0);
    add(0, 1, 0, 20, 5, 0, 10, 1, 0, 0);
    add(0, 1, 0, 20, 5, 0, 15, 1, 0, 0);
    add(0, 1, 0, 20, 5, 0, 20, 0, 1, 0);
    add(0, 1, 0, 20, 5, 0, 15, 0, 0, 0);
    add(0, 1, 0, 20, 5, 0, 10, 0, 0, 0);
    add(0, 1, 0, 20, 5, 0, 5, 0, 0, 0);
    add(0, 1, 0, 20, 5, 0, 0, 1, 0, 1);
    add(0, 1, 0, 20, 5, 0, 5, 1, 0, 0);
    add(0, 0, 0, 20, 5, 0, 5, 1, 0, 0);
    // 0..7 step 3 with dwell 2
    add(1, 0, 0, 7, 3, 2, 0, 1, 0, 0);
    add(0, 1, 0, 7, 3, 2, 3, 1, 0, 0);
    add(0, 1, 0, 7, 3, 2, 6, 1, 0, 0);
    add(0, 1, 0, 7, 3, 2, 7, 1, 1, 0);
    add(0, 1, 0, 7, 3, 2, 7, 1, 0, 0);
    add(0, 1, 0, 7, 3, 2, 7, 0, 0, 0);
    add(0, 1, 0, 7, 3, 2, 4, 0, 0, 0);
    add(0, 1, 0, 7, 3, 2, 1, 0, 0, 0);
    add(0, 1, 0, 7, 3, 2, 0, 0, 0, 1);
    add(0, 1, 0, 7, 3, 2, 0, 0, 0, 0);
    add(0, 1, 0, 7, 3, 2, 0, 1, 0, 0);
    add(0, 1, 0, 7, 3, 2, 3, 1, 0, 0);
    // step 0 behaves as 1
    add(1, 0, 5, 8, 0, 0, 5, 1, 0, 0);
    add(0, 1, 5, 8, 0, 0, 6, 1, 0, 0);
    add(0, 1, 5, 8, 0, 0, 7, 1, 0, 0);
    add(0, 1, 5, 8, 0, 0, 8, 0, 1, 0);
    add(0, 1, 5, 8, 0, 0, 7, 0, 0, 0);
    // full scale, no overflow
    add(1, 0, 0, 255, 255, 0, 0, 1, 0, 0);
    add(0, 1, 0, 255, 255, 0, 255, 0, 1, 0);
    add(0, 1, 0, 255, 255, 0, 0, 1, 0, 1);
    // degenerate bounds
    add(1, 0, 30, 30, 4, 0, 30, 1, 0, 0);
    add(0, 1, 30, 30, 4, 0, 30, 1, 0, 0);
    add(0, 1, 40, 10, 4, 0, 40, 1, 0, 0);
    add(0, 1, 40, 10, 4, 3, 40, 1, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].r, vt[i].e, vt[i].lo, vt[i].hi, vt[i].st, vt[i].dw);
      cycle();
      check($sformatf("vec%0d.out", i), 32'(bus.out), 32'(vt[i].out));
      check($sformatf("vec%0d.dir", i), 32'(bus.dir), 32'(vt[i].dir));
      check($sformatf("vec%0d.peak", i), 32'(bus.at_peak), 32'(vt[i].pk));
      check($sformatf("vec%0d.trough", i), 32'(bus.at_trough), 32'(vt[i].tr));
    end

    // hi lowered from 200 to 50 while rising at 120
    drive(1, 0, 0, 200, 40, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 200, 40, 0); cycle();
    end
    check("midramp.pre", 32'(bus.out), 32'd120);
    drive(0, 1, 0, 50, 40, 0); cycle();
    check("midramp.out", 32'(bus.out), 32'd50);
    check("midramp.peak", 32'(bus.at_peak), 32'd1);
    check("midramp.dir", 32'(bus.dir), 32'd0);
    drive(0, 0, 0, 50, 40, 0); cycle();
    check("midramp.peak_width", 32'(bus.at_peak), 32'd0);

    // dwell lowered below the elapsed hold count
    drive(1, 0, 0, 10, 10, 5); cycle();
    drive(0, 1, 0, 10, 10, 5); cycle();
    check("dwellchg.peak", 32'(bus.at_peak), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 10, 10, 5); cycle();
    end
    check("dwellchg.holding", 32'(bus.dir), 32'd1);
    drive(0, 1, 0, 10, 10, 2); cycle();
    check("dwellchg.exit_dir", 32'(bus.dir), 32'd0);
    check("dwellchg.exit_out", 32'(bus.out), 32'd10);
    drive(0, 1, 0, 10, 10, 2); cycle();
    check("dwellchg.trough_out", 32'(bus.out), 32'd0);
    check("dwellchg.trough", 32'(bus.at_trough), 32'd1);

    // randomized run: tick every 4th cycle first, then random ena
    l = 0; h = 200; s = 7; d = 2;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        l = $urandom_range(0, 255);
        h = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(l, 255);
        s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
        d = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
      end
      r = (c == 0) || ($urandom_range(0, 299) == 0);
      e = (c < 2000) ? (c % 4 == 3) : ($urandom_range(0, 1) == 1);
      drive(r, e, l, h, s, d);
      cycle();
      model_step(r, e, l, h, s, d);
      check($sformatf("rnd%0d.out", c), 32'(bus.out), 32'(m_val));
      check($sformatf("rnd%0d.dir", c), 32'(bus.dir), 32'(m_rising));
      check($sformatf("rnd%0d.peak", c), 32'(bus.at_peak), 32'(m_peak));
      check($sformatf("rnd%0d.trough", c), 32'(bus.at_trough), 32'(m_trough));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
